traffic_light_monitor: RTL and testbench

Passive checker on the 3-bit lamp bus driven by the traffic-light controller. It samples `lights_in` every clock, decodes the active phase, and measures how many cycles each phase is held. It flags illegal lamp encodings, out-of-order phase transitions and dwell-time violations. It sits beside the controller in the intersection top level and feeds sticky error flags and a completed-cycle counter to status/debug logic.

---
 rtl/traffic_light_pkg.sv | 36 +++
 rtl/traffic_light_decode.sv | 25 ++
 rtl/traffic_light_monitor.sv | 136 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light controller and its monitor.
// Holds phase and lamp encodings, default dwell times, the monitor state
// encoding and the legal successor function.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } phase_e;

  // Lamp bus: bit 2 red, bit 1 yellow, bit 0 green
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam int D_GREEN_DEF  = 11;
  localparam int D_YELLOW_DEF = 4;
  localparam int D_RED_DEF    = 16;

  typedef enum logic [1:0] {
    ACQUIRE = 2'b00,
    PARTIAL = 2'b01,
    TRACK   = 2'b10
  } mon_state_e;

  // GREEN -> YELLOW -> RED -> GREEN
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational lamp decoder.
// Ports:
//   lights : 3-bit lamp bus (red, yellow, green)
//   phase  : decoded phase (GREEN when illegal)
//   legal  : lamp value is exactly one-hot
module traffic_light_decode
  import traffic_light_pkg::*;
(
  input  logic [2:0] lights,
  output phase_e     phase,
  output logic       legal
);

  always_comb begin
    phase = GREEN;
    legal = 1'b1;
    case (lights)
      LAMP_GREEN:  phase = GREEN;
      LAMP_YELLOW: phase = YELLOW;
      LAMP_RED:    phase = RED;
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the traffic-light lamp bus.
// Decodes the phase each cycle, measures dwell, and raises sticky flags for
// illegal encodings, wrong phase order and dwell violations.
// Ports:
//   clk, reset            : clock, async active-high reset
//   lights_in [2:0]       : lamp bus from the controller
//   err_clear             : synchronous clear of the sticky flags
//   phase [1:0]           : current phase, qualified by phase_valid
//   dwell_cnt [CW-1:0]    : cycles the current phase has been held (saturating)
//   err_encoding/sequence/timing : sticky error flags
//   cycle_done            : pulse per checked RED->GREEN transition
//   cycle_count [15:0]    : count of checked RED->GREEN transitions (wraps)
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int D_GREEN  = D_GREEN_DEF,
  parameter int D_YELLOW = D_YELLOW_DEF,
  parameter int D_RED    = D_RED_DEF,
  parameter int CW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    lights_in,
  input  logic          err_clear,
  output logic [1:0]    phase,
  output logic          phase_valid,
  output logic [CW-1:0] dwell_cnt,
  output logic          err_encoding,
  output logic          err_sequence,
  output logic          err_timing,
  output logic          cycle_done,
  output logic [15:0]   cycle_count
);

  localparam logic [CW-1:0] DMAX = '1;

  mon_state_e    state, state_nx;
  phase_e        cur_ph, cur_ph_nx;
  logic [CW-1:0] dwell_nx, dwell_inc;
  logic          enc_ev, seq_ev, tim_ev, rg_ev;
  phase_e        in_ph;
  logic          in_legal;
  logic [63:0]   req_cur, dwell_ext;

  traffic_light_decode u_dec (
    .lights (lights_in),
    .phase  (in_ph),
    .legal  (in_legal)
  );

  // Compare in a wide domain so a required dwell larger than the counter
  // range simply never matches instead of aliasing after truncation.
  function automatic logic [63:0] req_dwell(input phase_e p);
    case (p)
      GREEN:   return 64'(D_GREEN);
      YELLOW:  return 64'(D_YELLOW);
      default: return 64'(D_RED);
    endcase
  endfunction

  assign req_cur   = req_dwell(cur_ph);
  assign dwell_ext = 64'(dwell_cnt);
  assign dwell_inc = (dwell_cnt == DMAX) ? dwell_cnt : dwell_cnt + CW'(1);

  always_comb begin
    state_nx  = state;
    cur_ph_nx = cur_ph;
    dwell_nx  = dwell_cnt;
    enc_ev    = 1'b0;
    seq_ev    = 1'b0;
    tim_ev    = 1'b0;
    rg_ev     = 1'b0;
    case (state)
      ACQUIRE: begin
        if (in_legal) begin
          cur_ph_nx = in_ph;
          dwell_nx  = CW'(1);
          state_nx  = PARTIAL;
        end else begin
          enc_ev = 1'b1;
        end
      end
      default: begin
        if (!in_legal) begin
          enc_ev   = 1'b1;
          dwell_nx = '0;
          state_nx = ACQUIRE;
        end else if (in_ph == cur_ph) begin
          dwell_nx = dwell_inc;
          // Overstay fires once, on the edge that would reach required+1;
          // later holds and the eventual transition stay silent.
          if (state == TRACK && dwell_ext == req_cur) tim_ev = 1'b1;
        end else begin
          cur_ph_nx = in_ph;
          dwell_nx  = CW'(1);
          state_nx  = TRACK;
          if (in_ph != next_phase(cur_ph)) begin
            seq_ev = 1'b1;
          end else if (state == TRACK) begin
            // PARTIAL phase start is unknown, so only TRACK checks dwell
            if (dwell_ext < req_cur) tim_ev = 1'b1;
            if (cur_ph == RED)       rg_ev  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACQUIRE;
      cur_ph       <= GREEN;
      dwell_cnt    <= '0;
      phase_valid  <= 1'b0;
      err_encoding <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
      cycle_done   <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state        <= state_nx;
      cur_ph       <= cur_ph_nx;
      dwell_cnt    <= dwell_nx;
      phase_valid  <= (state_nx != ACQUIRE);
      // A new error on the clearing edge wins
      err_encoding <= (err_encoding & ~err_clear) | enc_ev;
      err_sequence <= (err_sequence & ~err_clear) | seq_ev;
      err_timing   <= (err_timing   & ~err_clear) | tim_ev;
      cycle_done   <= rg_ev;
      cycle_count  <= cycle_count + {15'd0, rg_ev};
    end
  end

  assign phase = cur_ph;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor. Expected values are queued before
// each clock edge and compared just after it. A second CW=4 instance shares
// the stimulus to observe counter saturation.
module tb_traffic_light_monitor;

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  localparam int F_PH  = 0;
  localparam int F_PV  = 1;
  localparam int F_DW  = 2;
  localparam int F_ENC = 3;
  localparam int F_SEQ = 4;
  localparam int F_TIM = 5;
  localparam int F_CD  = 6;
  localparam int F_CC  = 7;
  localparam int F_DW4 = 8;

  logic        clk, reset, err_clear;
  logic [2:0]  lights_in;
  logic [1:0]  phase, phase4;
  logic        phase_valid, err_encoding, err_sequence, err_timing, cycle_done;
  logic [31:0] dwell_cnt;
  logic [15:0] cycle_count, cycle_count4;
  logic [3:0]  dwell_cnt4;
  logic        pv4, enc4, seq4, tim4, cd4;

  typedef struct {
    string       tag;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .lights_in(lights_in), .err_clear(err_clear),
    .phase(phase), .phase_valid(phase_valid), .dwell_cnt(dwell_cnt),
    .err_encoding(err_encoding), .err_sequence(err_sequence),
    .err_timing(err_timing), .cycle_done(cycle_done), .cycle_count(cycle_count)
  );

  traffic_light_monitor #(.CW(4)) dut4 (
    .clk(clk), .reset(reset), .lights_in(lights_in), .err_clear(err_clear),
    .phase(phase4), .phase_valid(pv4), .dwell_cnt(dwell_cnt4),
    .err_encoding(enc4), .err_sequence(seq4),
    .err_timing(tim4), .cycle_done(cd4), .cycle_count(cycle_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] observe(input int f);
    case (f)
      F_PH:    return {30'd0, phase};
      F_PV:    return {31'd0, phase_valid};
      F_DW:    return dwell_cnt;
      F_ENC:   return {31'd0, err_encoding};
      F_SEQ:   return {31'd0, err_sequence};
      F_TIM:   return {31'd0, err_timing};
      F_CD:    return {31'd0, cycle_done};
      F_CC:    return {16'd0, cycle_count};
      default: return {28'd0, dwell_cnt4};
    endcase
  endfunction

  task automatic want(input string tag, input int f, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.fld);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [2:0] l, input int n);
    lights_in = l;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset     = 1'b1;
    err_clear = 1'b0;
    lights_in = LG;
    #1;
    want("rst_ph", F_PH, 0);   want("rst_pv", F_PV, 0);  want("rst_dw", F_DW, 0);
    want("rst_enc", F_ENC, 0); want("rst_seq", F_SEQ, 0); want("rst_tim", F_TIM, 0);
    want("rst_cd", F_CD, 0);   want("rst_cc", F_CC, 0);
    check_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Acquire mid-GREEN; the partial phase is never timing-checked
    want("acq_pv", F_PV, 1); want("acq_dw", F_DW, 1); want("acq_ph", F_PH, 0);
    tick();
    hold(LG, 18);
    want("part_dw", F_DW, 20); want("part_dw4", F_DW4, 15); want("part_tim", F_TIM, 0);
    tick();

    // Nominal cycle 1
    hold(LY, 3);
    want("y_dw", F_DW, 4); want("y_ph", F_PH, 1); want("y_tim", F_TIM, 0);
    tick();
    hold(LR, 15);
    want("r_dw16", F_DW, 16); want("r_ph", F_PH, 2); want("r_tim", F_TIM, 0);
    tick();
    lights_in = LG;
    want("c1_cd", F_CD, 1); want("c1_cc", F_CC, 1); want("c1_dw", F_DW, 1); want("c1_tim", F_TIM, 0);
    tick();
    want("c1_cd_low", F_CD, 0); want("c1_dw2", F_DW, 2);
    tick();
    hold(LG, 9);
    // Nominal cycle 2
    hold(LY, 4);
    hold(LR, 16);
    lights_in = LG;
    want("c2_cd", F_CD, 1); want("c2_cc", F_CC, 2); want("c2_enc", F_ENC, 0);
    want("c2_seq", F_SEQ, 0); want("c2_tim", F_TIM, 0);
    tick();

    // Short GREEN (10 < 11)
    hold(LG, 9);
    lights_in = LY;
    want("short_tim", F_TIM, 1); want("short_seq", F_SEQ, 0);
    want("short_ph", F_PH, 1);   want("short_dw", F_DW, 1);
    tick();
    err_clear = 1'b1;
    want("clr_tim", F_TIM, 0); want("clr_dw", F_DW, 2);
    tick();
    err_clear = 1'b0;

    // YELLOW overstay: flag at the 5th edge, once
    hold(LY, 1);
    want("ovs_edge4_tim", F_TIM, 0); want("ovs_dw4", F_DW, 4);
    tick();
    want("ovs_edge5_tim", F_TIM, 1); want("ovs_dw5", F_DW, 5);
    tick();
    err_clear = 1'b1;
    want("ovs_edge6_tim", F_TIM, 0); want("ovs_dw6", F_DW, 6);
    tick();
    err_clear = 1'b0;
    lights_in = LR;
    want("ovs_trans_tim", F_TIM, 0); want("ovs_trans_ph", F_PH, 2);
    tick();
    hold(LR, 15);
    lights_in = LG;
    want("c3_cd", F_CD, 1); want("c3_cc", F_CC, 3); want("c3_tim", F_TIM, 0);
    tick();

    // GREEN -> RED skip
    hold(LG, 10);
    lights_in = LR;
    want("skip_seq", F_SEQ, 1); want("skip_ph", F_PH, 2); want("skip_dw", F_DW, 1);
    want("skip_pv", F_PV, 1);   want("skip_tim", F_TIM, 0); want("skip_cd", F_CD, 0);
    tick();
    err_clear = 1'b1;
    want("skip_clr_seq", F_SEQ, 0); want("skip_dw2", F_DW, 2);
    tick();
    err_clear = 1'b0;
    hold(LR, 14);
    lights_in = LG;
    want("c4_cd", F_CD, 1); want("c4_cc", F_CC, 4); want("c4_tim", F_TIM, 0); want("c4_seq", F_SEQ, 0);
    tick();

    // Illegal encoding 110 for two cycles, then reacquire
    lights_in = 3'b110;
    want("enc1_enc", F_ENC, 1); want("enc1_pv", F_PV, 0); want("enc1_dw", F_DW, 0);
    tick();
    want("enc2_pv", F_PV, 0); want("enc2_dw", F_DW, 0); want("enc2_enc", F_ENC, 1);
    tick();
    lights_in = LG;
    want("reacq_pv", F_PV, 1); want("reacq_dw", F_DW, 1); want("reacq_ph", F_PH, 0);
    want("reacq_cc", F_CC, 4);
    tick();

    // err_clear on the same edge as a short-dwell detection
    err_clear = 1'b1;
    want("enc_clr", F_ENC, 0);
    tick();
    err_clear = 1'b0;
    lights_in = LY;
    want("trk_y_ph", F_PH, 1); want("trk_y_tim", F_TIM, 0);
    tick();
    hold(LY, 1);
    err_clear = 1'b1;
    lights_in = LR;
    want("clr_race_tim", F_TIM, 1); want("clr_race_ph", F_PH, 2);
    tick();
    err_clear = 1'b0;

    // Saturation in the CW=4 instance
    lights_in = LG;
    tick();
    hold(LG, 23);
    want("sat_dw4", F_DW4, 15); want("wide_dw", F_DW, 25);
    tick();

    // Asynchronous reset mid-phase, then reacquire
    #2;
    reset = 1'b1;
    #1;
    want("arst_pv", F_PV, 0); want("arst_dw", F_DW, 0); want("arst_cc", F_CC, 0);
    want("arst_tim", F_TIM, 0); want("arst_dw4", F_DW4, 0);
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    want("post_rst_pv", F_PV, 1); want("post_rst_dw", F_DW, 1); want("post_rst_cd", F_CD, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
